// File: rtl/encryption.sv
//------------------------------------------------------------------------------
// Module      : encryption
// Description : Single-character encryption stage, C = (Plaintext + Public_key)
//               mod 256, fully registered with one-cycle latency.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module encryption #(
    parameter logic [7:0] NUL_CHAR = 8'h00,
    parameter logic [1:0] MODE_ENC = 2'b10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [7:0] Plaintext,
    input  logic [7:0] Public_key,
    output logic [7:0] Char_ciphertext,
    output logic       C_ready,
    output logic       err_invalid_ptxt
);

    logic [7:0] cipher_q, cipher_d;
    logic       ready_q,  ready_d;
    logic       err_q,    err_d;

    logic       w_enc;
    logic       w_ptxt_valid;
    logic [7:0] w_sum;

    assign w_enc        = (mode == MODE_ENC);
    assign w_ptxt_valid = ~Plaintext[7];
    // 8-bit sum: the carry out of bit 7 is dropped, giving mod-256 wrap.
    assign w_sum        = Plaintext + Public_key;

    always_comb begin
        cipher_d = cipher_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        if (w_enc) begin
            if (w_ptxt_valid) begin
                cipher_d = w_sum;
                ready_d  = 1'b1;
            end else begin
                cipher_d = NUL_CHAR;
                err_d    = 1'b1;
            end
        end
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cipher_q <= NUL_CHAR;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cipher_q <= cipher_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign Char_ciphertext  = cipher_q;
    assign C_ready          = ready_q;
    assign err_invalid_ptxt = err_q;

endmodule

`default_nettype wire

// File: tb/tb_encryption.sv
//------------------------------------------------------------------------------
// Module      : tb_encryption
// Description : Self-checking bench for encryption: directed vector table plus
//               randomized stream against a behavioural model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_encryption;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [7:0] Plaintext;
    logic [7:0] Public_key;
    logic [7:0] Char_ciphertext;
    logic       C_ready;
    logic       err_invalid_ptxt;

    int n_checks = 0;
    int n_errors = 0;

    encryption dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mode             (mode),
        .Plaintext        (Plaintext),
        .Public_key       (Public_key),
        .Char_ciphertext  (Char_ciphertext),
        .C_ready          (C_ready),
        .err_invalid_ptxt (err_invalid_ptxt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] md;
        logic [7:0] pt;
        logic [7:0] key;
        logic [7:0] exp_c;
        logic       exp_rdy;
        logic       exp_err;
    } vec_t;

    vec_t vecs[16];

    // Behavioural model state: what the outputs should show after the last edge.
    logic [7:0] m_c;
    logic       m_rdy;
    logic       m_err;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] c, input logic r, input logic e);
        check({tag, ".cipher"}, Char_ciphertext, c);
        check({tag, ".ready"},  {7'd0, C_ready}, {7'd0, r});
        check({tag, ".err"},    {7'd0, err_invalid_ptxt}, {7'd0, e});
    endtask

    task automatic model_edge(input logic r, input logic [1:0] md, input logic [7:0] pt, input logic [7:0] key);
        int sum;
        if (r) begin
            m_c = 8'h00; m_rdy = 1'b0; m_err = 1'b0;
        end else if (md == 2'b10) begin
            if (pt < 8'h80) begin
                sum   = (int'(pt) + int'(key)) % 256;
                m_c   = sum[7:0];
                m_rdy = 1'b1;
                m_err = 1'b0;
            end else begin
                m_c = 8'h00; m_rdy = 1'b0; m_err = 1'b1;
            end
        end else begin
            m_rdy = 1'b0; m_err = 1'b0;
        end
    endtask

    initial begin
        //           rst   mode   pt     key    c      rdy   err
        vecs[0]  = '{1'b1, 2'b10, 8'h41, 8'h03, 8'h00, 1'b0, 1'b0}; // reset
        vecs[1]  = '{1'b1, 2'b10, 8'h41, 8'h03, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'b10, 8'h7F, 8'hC8, 8'h47, 1'b1, 1'b0}; // nominal 'G'
        vecs[3]  = '{1'b0, 2'b10, 8'h7F, 8'hC8, 8'h47, 1'b1, 1'b0}; // stable
        vecs[4]  = '{1'b0, 2'b00, 8'h12, 8'hC8, 8'h47, 1'b0, 1'b0}; // idle hold
        vecs[5]  = '{1'b0, 2'b10, 8'h80, 8'h01, 8'h00, 1'b0, 1'b1}; // invalid
        vecs[6]  = '{1'b0, 2'b11, 8'h05, 8'h01, 8'h00, 1'b0, 1'b0}; // reserved hold
        vecs[7]  = '{1'b0, 2'b10, 8'h41, 8'h03, 8'h44, 1'b1, 1'b0}; // no wrap
        vecs[8]  = '{1'b0, 2'b10, 8'h7F, 8'hFF, 8'h7E, 1'b1, 1'b0}; // wrap
        vecs[9]  = '{1'b0, 2'b01, 8'h33, 8'h44, 8'h7E, 1'b0, 1'b0}; // reserved hold
        vecs[10] = '{1'b0, 2'b10, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 2'b10, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1}; // invalid
        vecs[13] = '{1'b0, 2'b10, 8'h10, 8'h10, 8'h20, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 2'b10, 8'h10, 8'h10, 8'h00, 1'b0, 1'b0}; // reset mid-stream
        vecs[15] = '{1'b0, 2'b10, 8'h01, 8'h01, 8'h02, 1'b1, 1'b0}; // resume

        rst_n = 1'b1; mode = 2'b00; Plaintext = 8'h00; Public_key = 8'h00;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            rst_n      = vecs[i].rst;
            mode       = vecs[i].md;
            Plaintext  = vecs[i].pt;
            Public_key = vecs[i].key;
            @(posedge clk); #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_c, vecs[i].exp_rdy, vecs[i].exp_err);
        end

        // Mid-cycle input change must not reach the outputs before the next edge.
        mode = 2'b10; Plaintext = 8'h20; Public_key = 8'h05;
        #2;
        check_outputs("nocomb", 8'h02, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_outputs("nocomb_next", 8'h25, 1'b1, 1'b0);

        // Model starts from the known post-vector state.
        m_c = 8'h25; m_rdy = 1'b1; m_err = 1'b0;

        for (int i = 0; i < 400; i++) begin
            rst_n      = ($urandom_range(0, 24) == 0);
            mode       = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            Plaintext  = 8'($urandom);
            Public_key = 8'($urandom);
            #2;
            check_outputs("rnd_pre", m_c, m_rdy, m_err);
            model_edge(rst_n, mode, Plaintext, Public_key);
            @(posedge clk); #1;
            check_outputs("rnd", m_c, m_rdy, m_err);
            n_checks++;
            if ((C_ready & err_invalid_ptxt) || $isunknown({Char_ciphertext, C_ready, err_invalid_ptxt})) begin
                n_errors++;
                $display("FAIL excl_x: actual ready=%b err=%b c=%h required exclusive/known", C_ready, err_invalid_ptxt, Char_ciphertext);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/encryption.md
Name: encryption

Overview:
- Single-character encryption stage: takes one 8-bit plaintext character and an 8-bit public key, and produces one 8-bit ciphertext character.
- Operation is gated by a 2-bit mode word; mode 2'b10 is the encryption command.
- Sits between the character source and the ciphertext sink or transmitter of the crypto datapath.
- Fully registered: one result per clock, streaming.

Parameters:
- NUL_CHAR, 8'h00, value driven on Char_ciphertext at reset and on an invalid plaintext.
- MODE_ENC, 2'b10, mode encoding that enables encryption.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst_n  input  1  reset; synchronous, active-high despite the name (1 = reset, sampled on the clk rising edge).
- mode  input  2  operation select; only 2'b10 encrypts.
- Plaintext  input  8  plaintext character; valid range 8'h00..8'h7F (7-bit ASCII).
- Public_key  input  8  public key byte; every value 8'h00..8'hFF is legal.
- Char_ciphertext  output  8  registered ciphertext character.
- C_ready  output  1  registered; high when Char_ciphertext holds a valid result of the previous cycle's inputs.
- err_invalid_ptxt  output  1  registered; high when the previous cycle's encrypt request had an invalid plaintext.

Behaviour:
- Reset (rst_n = 1 at a clk rising edge):
  - Char_ciphertext = NUL_CHAR, C_ready = 0, err_invalid_ptxt = 0.
  - Reset overrides all other inputs on that edge.
- Validity check: Plaintext is valid when Plaintext[7] = 0; Plaintext[7] = 1 is invalid.
- Cipher function: C = (Plaintext + Public_key) mod 256.
  - Unsigned 8-bit addition; the carry out of bit 7 is discarded (wrap-around).
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N, and stay stable until edge N+1.
- Per rising edge, when not in reset:
  - mode = 2'b10, Plaintext valid: Char_ciphertext <= C; C_ready <= 1; err_invalid_ptxt <= 0.
  - mode = 2'b10, Plaintext invalid: Char_ciphertext <= NUL_CHAR; C_ready <= 0; err_invalid_ptxt <= 1.
  - mode = 00, 01 or 11 (idle/reserved): Char_ciphertext holds its last value; C_ready <= 0; err_invalid_ptxt <= 0.
- Streaming:
  - A new character may be presented every cycle; no backpressure, no handshake input.
  - C_ready stays high across consecutive valid encrypt cycles.
  - With inputs held constant in mode 2'b10, the outputs are constant.
- Exclusivity: C_ready and err_invalid_ptxt are never high in the same cycle.
- Reset mid-stream: the result in flight is discarded and outputs return to reset values on that edge. Operation resumes on the first edge with rst_n = 0.
- No combinational path from inputs to outputs.
- Outputs are never X after the first reset edge.

Test Plan:
- Reset: assert rst_n = 1 for 2 cycles, then release -> Char_ciphertext = 8'h00, C_ready = 0, err_invalid_ptxt = 0.
- Nominal encrypt: mode = 2'b10, Public_key = 8'hC8, Plaintext = 8'h7F -> one cycle later Char_ciphertext = 8'h47 ('G'), C_ready = 1, err_invalid_ptxt = 0, stable on following cycles.
- Invalid plaintext: mode = 2'b10, Plaintext = 8'h80, Public_key = 8'h01 -> Char_ciphertext = 8'h00, C_ready = 0, err_invalid_ptxt = 1.
- No wrap: Plaintext = 8'h41, Public_key = 8'h03 -> Char_ciphertext = 8'h44.
- Wrap-around: Plaintext = 8'h7F, Public_key = 8'hFF -> Char_ciphertext = 8'h7E.
- Idle hold: after the nominal encrypt result, set mode = 2'b00 and change Plaintext -> Char_ciphertext holds 8'h47, C_ready = 0.
- Reset mid-stream: assert rst_n = 1 during mode = 2'b10 streaming -> next cycle all outputs at reset values.
